// File: rtl/fb_writer.sv
// Wishbone write master: buffers an RGB888 pixel stream as RGB565 and writes it
// row-major into the SDRAM framebuffer at BASE_ADR + 2*(HDISP*y + x).
module fb_writer #(
    parameter int unsigned HDISP       = 640,
    parameter int unsigned VDISP       = 480,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int unsigned DEPTH_WIDTH = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [1:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_adr,
    output logic [15:0] wshb_dat_ms,
    input  logic        wshb_ack,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int unsigned XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned CW    = DEPTH_WIDTH + 1;

    typedef enum logic {SYNC, RUN} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sync_err_q, sync_err_d;
    logic [16:0]            mem_q [DEPTH];

    logic        fifo_empty, fifo_full, push, pop, head_sof;
    logic [16:0] head;
    logic [XW-1:0] x_eff;
    logic [YW-1:0] y_eff;
    logic [31:0] pix_idx;
    logic        unused_lsbs;

    assign unused_lsbs = ^{pix_r[2:0], pix_g[1:0], pix_b[2:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign head_sof   = head[16];
    assign x_eff      = head_sof ? '0 : x_q;
    assign y_eff      = head_sof ? '0 : y_q;
    assign pix_idx    = 32'(HDISP) * 32'(y_eff) + 32'(x_eff);

    // Ready depends only on the registered fill level: no push into a full FIFO even if it pops.
    assign pix_ready   = (state_q == SYNC) || !fifo_full;
    assign wshb_cyc    = !fifo_empty;
    assign wshb_stb    = !fifo_empty;
    assign wshb_we     = 1'b1;
    assign wshb_sel    = 2'b11;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign wshb_adr    = BASE_ADR + {pix_idx[30:0], 1'b0};
    assign wshb_dat_ms = head[15:0];
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;

        push = pix_valid && pix_ready && ((state_q == RUN) || pix_sof);
        pop  = wshb_stb && wshb_ack;

        if (push && (state_q == SYNC)) begin
            state_d = RUN;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // Write acknowledged: retire head and step the raster position.
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + DEPTH_WIDTH'(1);
            frame_done_d = (x_eff == XW'(HDISP - 1)) && (y_eff == YW'(VDISP - 1));
            if (head_sof) begin
                x_d = XW'(1);
                y_d = '0;
                if ((x_q != '0) || (y_q != '0)) begin
                    sync_err_d = 1'b1;
                end
            end else if (x_q == XW'(HDISP - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(VDISP - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= SYNC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Pixel storage, converted to RGB565 on entry.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pix_sof, pix_r[7:3], pix_g[7:2], pix_b[7:3]};
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Randomised and directed bench for fb_writer against a queue-based reference model.
module tb_fb_writer;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0, pix_sof = 1'b0, wshb_ack = 1'b0;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic        pix_ready, wshb_cyc, wshb_stb, wshb_we, frame_done, sync_err;
    logic [1:0]  wshb_sel, wshb_bte;
    logic [2:0]  wshb_cti;
    logic [31:0] wshb_adr;
    logic [15:0] wshb_dat_ms;

    fb_writer #(.HDISP(H), .VDISP(V), .BASE_ADR(BASE), .DEPTH_WIDTH(4)) dut (
        .CLK(CLK), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
        .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
        .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_ack(wshb_ack),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: queue of pending writes plus raster position.
    logic [16:0] mq[$];
    int          mx = 0, my = 0;
    bit          synced = 0, m_serr = 0, m_fd = 0;
    int          checks = 0, errors = 0;
    int          fd_count = 0, accepted = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !synced || (mq.size() < DEPTH);
    endfunction

    function automatic logic [15:0] to565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Compare every observable output against the model (called on the falling edge).
    task automatic compare();
        int xe, ye;
        chk("pix_ready", 32'(pix_ready), 32'(exp_ready()));
        chk("stb", 32'(wshb_stb), 32'(mq.size() != 0));
        chk("cyc", 32'(wshb_cyc), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            xe = mq[0][16] ? 0 : mx;
            ye = mq[0][16] ? 0 : my;
            chk("adr", wshb_adr, BASE + 32'(2 * (H * ye + xe)));
            chk("dat", 32'(wshb_dat_ms), 32'(mq[0][15:0]));
        end
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("sync_err", 32'(sync_err), 32'(m_serr));
        chk("consts", {23'd0, wshb_we, wshb_sel, wshb_cti, wshb_bte},
            {23'd0, 1'b1, 2'b11, 3'b000, 2'b00});
        if (frame_done === 1'b1) fd_count++;
    endtask

    // Drive one cycle of inputs, advance the model at the rising edge, check at the falling edge.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [23:0] rgb, input logic a);
        bit xfer, stb_e;
        logic [16:0] hd;
        int idx;
        rst = r; pix_valid = v; pix_sof = s; wshb_ack = a;
        {pix_r, pix_g, pix_b} = rgb;
        xfer  = v && exp_ready();
        stb_e = (mq.size() != 0);
        @(posedge CLK);
        if (r) begin
            mq.delete(); mx = 0; my = 0; synced = 0; m_serr = 0; m_fd = 0;
        end else begin
            m_fd = 0;
            if (stb_e && a) begin
                hd = mq.pop_front();
                if (hd[16]) begin
                    if (mx != 0 || my != 0) m_serr = 1;
                    m_fd = (H == 1) && (V == 1);
                    mx = 1; my = 0;
                end else begin
                    m_fd = (mx == H - 1) && (my == V - 1);
                    idx = (my * H + mx + 1) % (H * V);
                    mx = idx % H; my = idx / H;
                end
            end
            if (xfer && (synced || s)) begin
                mq.push_back({s, to565(rgb)});
                synced = 1;
                accepted++;
            end
        end
        @(negedge CLK);
        compare();
    endtask

    initial begin
        repeat (3) step(1, 0, 0, 24'h0, 0);
        chk("reset_stb", 32'(wshb_stb), 32'd0);
        chk("reset_ready", 32'(pix_ready), 32'd1);

        // Pixels before any start-of-frame are swallowed.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 24'($urandom), 1);
            chk("sync_ready", 32'(pix_ready), 32'd1);
        end
        chk("drop_stb", 32'(wshb_stb), 32'd0);

        step(0, 1, 1, 24'hFF00FF, 0);
        chk("first_dat", 32'(wshb_dat_ms), 32'h0000F81F);
        chk("first_adr", wshb_adr, BASE);
        step(0, 0, 0, 24'h0, 1);
        chk("first_stb_off", 32'(wshb_stb), 32'd0);

        // One full 4x2 frame plus the wrap pixel, acked every cycle.
        step(1, 0, 0, 24'h0, 0);
        fd_count = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, (i == 0), 24'($urandom), 1);
            chk("frame_adr", wshb_adr, BASE + 32'(2 * (i % 8)));
        end
        step(0, 0, 0, 24'h0, 1);
        chk("frame_done_count", 32'(fd_count), 32'd1);
        chk("frame_sync_err", 32'(sync_err), 32'd0);

        // Slave stalls 40 cycles with the source streaming.
        step(1, 0, 0, 24'h0, 0);
        accepted = 0;
        step(0, 1, 1, 24'($urandom), 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 24'($urandom), 0);
        chk("stall_accepted", 32'(accepted), 32'd16);
        chk("stall_ready", 32'(pix_ready), 32'd0);
        for (int i = 0; i < 40; i++) step(0, 1'($urandom % 2), 0, 24'($urandom), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 24'h0, 1);
        chk("stall_drained", 32'(wshb_stb), 32'd0);

        // Start-of-frame out of place at (2,1).
        step(1, 0, 0, 24'h0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, (i == 0 || i == 6), 24'($urandom), 1);
            if (i == 6) chk("resync_adr", wshb_adr, BASE);
            if (i == 7) chk("resync_next_adr", wshb_adr, BASE + 32'd2);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 24'h0, 1);
        chk("sync_err_set", 32'(sync_err), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 24'($urandom), 1);
        chk("sync_err_sticky", 32'(sync_err), 32'd1);

        // Reset with a write outstanding.
        step(0, 1, 0, 24'($urandom), 0);
        chk("pending_stb", 32'(wshb_stb), 32'd1);
        step(1, 0, 0, 24'h0, 0);
        chk("rst_stb", 32'(wshb_stb), 32'd0);
        chk("rst_cyc", 32'(wshb_cyc), 32'd0);
        step(0, 1, 1, 24'($urandom), 0);
        chk("rst_restart_adr", wshb_adr, BASE);
        chk("rst_sync_err", 32'(sync_err), 32'd0);

        // Random traffic with occasional sof and reset.
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 500) == 0), 1'(($urandom % 10) < 7),
                 1'(($urandom % 40) == 0), 24'($urandom), 1'(($urandom % 10) < 6));
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0, 24'h0, 1);
        chk("final_drained", 32'(wshb_stb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
